// File: rtl/uart_pkg.sv
// Shared UART arbiter types.
// State encodings and default byte width.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_ISSUE      = 2'd1,
    ARB_WAIT_START = 2'd2,
    ARB_WAIT_DONE  = 2'd3
  } arb_state_t;

  localparam int UART_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker.
// First set req at or after ptr, wrapping.
module uart_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  // Scan from farthest to nearest offset; the nearest hit is written last.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX
// between NUM_REQ byte sources.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int START_TMO  = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Arb_En,
  input  logic [NUM_REQ-1:0]            Req_Valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
  input  logic [NUM_REQ-1:0]            Req_Par_En,
  output logic [NUM_REQ-1:0]            Req_Ack,
  output logic [NUM_REQ-1:0]            Req_Done,
  output logic [$clog2(NUM_REQ)-1:0]    Grant_Id,
  output logic                          Arb_Busy,
  output logic                          Err_Tmo,
  output logic [DATA_WIDTH-1:0]         TX_P_DATA,
  output logic                          TX_Data_Valid,
  output logic                          TX_Par_En,
  input  logic                          TX_Busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TMO);

  arb_state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               grant_go;
  logic               tmo_hit;
  logic [IW-1:0]      ptr_nxt;
  logic [NUM_REQ-1:0] gid_hot;

  uart_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req(Req_Valid),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );

  assign grant_go = Arb_En & (|Req_Valid) & ~TX_Busy;
  // The increment on this cycle lands the counter on START_TMO-1.
  assign tmo_hit  = (cnt == CW'(START_TMO - 2));
  assign gid_hot  = NUM_REQ'(1) << Grant_Id;
  assign ptr_nxt  = (Grant_Id == IW'(NUM_REQ - 1))
                  ? '0 : Grant_Id + 1'b1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ARB_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE:
        if (grant_go) state_nxt = ARB_ISSUE;
      ARB_ISSUE:
        state_nxt = ARB_WAIT_START;
      ARB_WAIT_START:
        if (TX_Busy)      state_nxt = ARB_WAIT_DONE;
        else if (tmo_hit) state_nxt = ARB_IDLE;
      ARB_WAIT_DONE:
        if (!TX_Busy) state_nxt = ARB_IDLE;
      default:
        state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    Arb_Busy      = (state != ARB_IDLE);
    TX_Data_Valid = (state == ARB_ISSUE);
    Req_Ack       = (state == ARB_ISSUE) ? gid_hot : '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt       <= '0;
      ptr       <= '0;
      Grant_Id  <= '0;
      TX_P_DATA <= '0;
      TX_Par_En <= 1'b0;
      Req_Done  <= '0;
      Err_Tmo   <= 1'b0;
    end else begin
      Req_Done <= '0;
      Err_Tmo  <= 1'b0;
      unique case (state)
        ARB_IDLE:
          if (grant_go) begin
            TX_P_DATA <= Req_Data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            TX_Par_En <= |(Req_Par_En & pick_gnt);
            Grant_Id  <= pick_idx;
          end
        ARB_ISSUE:
          cnt <= '0;
        ARB_WAIT_START:
          if (!TX_Busy) begin
            if (cnt != '1) cnt <= cnt + 1'b1;
            if (tmo_hit) Err_Tmo <= 1'b1;
          end
        ARB_WAIT_DONE:
          if (!TX_Busy) begin
            Req_Done <= gid_hot;
            ptr      <= ptr_nxt;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a
// behavioural TX busy model.
module tb_uart_tx_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Arb_En = 1'b0;
  logic [3:0]  Req_Valid = '0;
  logic [31:0] Req_Data = '0;
  logic [3:0]  Req_Par_En = '0;
  logic [3:0]  Req_Ack;
  logic [3:0]  Req_Done;
  logic [1:0]  Grant_Id;
  logic        Arb_Busy;
  logic        Err_Tmo;
  logic [7:0]  TX_P_DATA;
  logic        TX_Data_Valid;
  logic        TX_Par_En;
  logic        TX_Busy;

  logic        tx_en = 1'b1;
  int          rem;
  int          n_chk = 0;
  int          n_err = 0;
  bit          have_prev = 0;
  bit          gap_ok = 0;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .START_TMO(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Arb_En(Arb_En),
    .Req_Valid(Req_Valid),
    .Req_Data(Req_Data),
    .Req_Par_En(Req_Par_En),
    .Req_Ack(Req_Ack),
    .Req_Done(Req_Done),
    .Grant_Id(Grant_Id),
    .Arb_Busy(Arb_Busy),
    .Err_Tmo(Err_Tmo),
    .TX_P_DATA(TX_P_DATA),
    .TX_Data_Valid(TX_Data_Valid),
    .TX_Par_En(TX_Par_En),
    .TX_Busy(TX_Busy)
  );

  always #5 CLK = ~CLK;

  // TX model: busy from the cycle after Data_Valid, 11 cycles (10 without parity).
  always @(posedge CLK or negedge RST) begin
    if (!RST)                        rem <= 0;
    else if (tx_en && TX_Data_Valid) rem <= TX_Par_En ? 11 : 10;
    else if (rem != 0)               rem <= rem - 1;
  end
  assign TX_Busy = (rem != 0);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (TX_Data_Valid) begin
        if (have_prev) chk("gap", 32'(gap_ok), 1);
        have_prev = 1;
        gap_ok    = 0;
      end else if (!TX_Busy) begin
        gap_ok = 1;
      end
    end
  end

  task automatic set_data(input logic [7:0] d0, d1, d2, d3);
    Req_Data = {d3, d2, d1, d0};
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST       = 1'b0;
    Req_Valid = '0;
    Arb_En    = 1'b1;
    tx_en     = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic expect_frame(input int id, input logic [7:0] d,
                              input logic p, input bit clr);
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (TX_Data_Valid) break;
    end
    if (!TX_Data_Valid) begin
      chk("dv_wait", 0, 1);
    end else begin
      chk("gid",  32'(Grant_Id), 32'(id));
      chk("ack",  32'(Req_Ack), 32'(1) << id);
      chk("data", 32'(TX_P_DATA), 32'(d));
      chk("par",  32'(TX_Par_En), 32'(p));
      if (clr) Req_Valid[id] = 1'b0;
    end
  endtask

  task automatic wait_done(input logic [3:0] exp, output int cyc);
    cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (Req_Done != 0) begin
        cyc = k;
        break;
      end
    end
    chk("done", 32'(Req_Done), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int k;
    int dvs;
    bit done_seen;

    // 1: reset state and single request
    do_reset();
    chk("rst_busy", 32'(Arb_Busy), 0);
    chk("rst_dv",   32'(TX_Data_Valid), 0);
    chk("rst_data", 32'(TX_P_DATA), 0);
    chk("rst_gid",  32'(Grant_Id), 0);
    set_data(8'hA5, 8'h00, 8'h00, 8'h00);
    Req_Par_En = 4'b0001;
    Req_Valid  = 4'b0001;
    @(negedge CLK);
    chk("t1_dv",   32'(TX_Data_Valid), 1);
    chk("t1_ack",  32'(Req_Ack), 32'h1);
    chk("t1_data", 32'(TX_P_DATA), 32'hA5);
    chk("t1_par",  32'(TX_Par_En), 1);
    Req_Valid = 4'b0000;
    wait_done(4'b0001, cyc);
    chk("t1_done_lat", 32'(cyc), 13);

    // 2: all requesting, order 0,1,2,3,0
    do_reset();
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    Req_Par_En = 4'b1111;
    Req_Valid  = 4'b1111;
    for (int i = 0; i < 5; i++)
      expect_frame(i % 4, 8'h10 + 8'(i % 4), 1'b1, 1'b0);
    Req_Valid = 4'b0000;
    wait_done(4'b0001, cyc);

    // 3: pointer at 2, late request from 1
    set_data(8'h20, 8'h21, 8'h22, 8'h23);
    Req_Par_En = 4'b0101;
    Req_Valid  = 4'b0010;
    expect_frame(1, 8'h21, 1'b0, 1'b1);
    wait_done(4'b0010, cyc);
    Req_Valid = 4'b1001;
    expect_frame(3, 8'h23, 1'b0, 1'b1);
    repeat (3) @(negedge CLK);
    Req_Valid[1] = 1'b1;
    expect_frame(0, 8'h20, 1'b1, 1'b1);
    expect_frame(1, 8'h21, 1'b0, 1'b1);
    wait_done(4'b0010, cyc);

    // 4: start timeout, retry keeps the same requester
    set_data(8'h00, 8'h00, 8'h44, 8'h77);
    Req_Par_En = 4'b0000;
    tx_en      = 1'b0;
    Req_Valid  = 4'b1100;
    expect_frame(2, 8'h44, 1'b0, 1'b0);
    done_seen = 0;
    for (k = 1; k <= 30; k++) begin
      @(negedge CLK);
      if (Req_Done != 0) done_seen = 1;
      if (Err_Tmo) break;
    end
    chk("tmo_lat",    32'(k), 16);
    chk("tmo_idle",   32'(Arb_Busy), 0);
    chk("tmo_nodone", 32'(done_seen), 0);
    tx_en = 1'b1;
    expect_frame(2, 8'h44, 1'b0, 1'b1);
    expect_frame(3, 8'h77, 1'b0, 1'b1);
    wait_done(4'b1000, cyc);

    // 5: Arb_En dropped mid-frame
    set_data(8'h55, 8'h66, 8'h00, 8'h00);
    Req_Valid = 4'b0001;
    expect_frame(0, 8'h55, 1'b0, 1'b1);
    repeat (4) @(negedge CLK);
    Arb_En    = 1'b0;
    Req_Valid = 4'b0010;
    wait_done(4'b0001, cyc);
    dvs = 0;
    repeat (20) begin
      @(negedge CLK);
      if (TX_Data_Valid) dvs++;
    end
    chk("en_off_dv",   32'(dvs), 0);
    chk("en_off_busy", 32'(Arb_Busy), 0);
    Arb_En = 1'b1;
    expect_frame(1, 8'h66, 1'b0, 1'b1);
    wait_done(4'b0010, cyc);

    // 6: reset during WAIT_DONE
    set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    Req_Par_En = 4'b1111;
    Req_Valid  = 4'b1000;
    expect_frame(3, 8'hA3, 1'b1, 1'b1);
    repeat (5) @(negedge CLK);
    Req_Valid = 4'b0101;
    RST       = 1'b0;
    #1;
    chk("mrst_busy", 32'(Arb_Busy), 0);
    chk("mrst_dv",   32'(TX_Data_Valid), 0);
    chk("mrst_ack",  32'(Req_Ack), 0);
    chk("mrst_done", 32'(Req_Done), 0);
    chk("mrst_err",  32'(Err_Tmo), 0);
    chk("mrst_gid",  32'(Grant_Id), 0);
    chk("mrst_data", 32'(TX_P_DATA), 0);
    chk("mrst_par",  32'(TX_Par_En), 0);
    @(negedge CLK);
    RST = 1'b1;
    expect_frame(0, 8'hA0, 1'b1, 1'b1);
    expect_frame(2, 8'hA2, 1'b1, 1'b1);
    wait_done(4'b0100, cyc);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
